// File: rtl/ttc_pkg.sv
// Shared types and helpers for the truth-table exerciser and its reference models.
package ttc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        SAMPLE = 2'd2,
        FINISH = 2'd3
    } ttc_state_e;

    // Tables are widened to this size so one helper serves every N_IN up to 8.
    localparam int unsigned VEC_IDX_W   = 8;
    localparam int unsigned TABLE_MAX_W = 1 << VEC_IDX_W;

    function automatic logic expected_bit(input logic [TABLE_MAX_W-1:0] tbl,
                                          input logic [VEC_IDX_W-1:0]   vec);
        return tbl[vec];
    endfunction

endpackage

// File: rtl/truth_table_checker_settle_timer.sv
// Settle-time counter: counts held cycles of one vector, flags the last one.
module settle_timer
    import ttc_pkg::*;
#(
    parameter int unsigned SETTLE = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic en,
    output logic hit
);

    localparam int unsigned CNT_W = $clog2(SETTLE + 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign hit = (count_q == CNT_W'(SETTLE - 1));

endmodule

// File: rtl/truth_table_checker.sv
// Walks every input vector of a small combinational function, samples its
// output after a settle time and scores it against an expected truth table.
module truth_table_checker
    import ttc_pkg::*;
#(
    parameter int unsigned          N_IN     = 3,
    parameter logic [(1<<N_IN)-1:0] EXPECTED = 8'h4F,
    parameter int unsigned          SETTLE   = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    output logic [N_IN-1:0] dut_in,
    input  logic            dut_out,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   fail_count,
    output logic [N_IN-1:0] first_fail_vec,
    output logic            first_fail_valid
);

    localparam logic [TABLE_MAX_W-1:0] TABLE_EXT = TABLE_MAX_W'(EXPECTED);
    localparam logic [N_IN-1:0]        LAST_VEC  = '1;

    ttc_state_e      state_q, state_d;
    logic [N_IN-1:0] vector_q, vector_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;
    logic [N_IN:0]   fail_count_q, fail_count_d;
    logic [N_IN-1:0] first_fail_vec_q, first_fail_vec_d;
    logic            first_fail_valid_q, first_fail_valid_d;

    logic timer_clear;
    logic timer_en;
    logic timer_hit;
    logic mismatch;

    assign timer_en    = (state_q == APPLY);
    assign timer_clear = (state_q != APPLY);

    settle_timer #(
        .SETTLE (SETTLE)
    ) u_settle_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (timer_clear),
        .en      (timer_en),
        .hit     (timer_hit)
    );

    assign mismatch = (dut_out != expected_bit(TABLE_EXT, VEC_IDX_W'(vector_q)));

    always_comb begin
        state_d            = state_q;
        vector_d           = vector_q;
        busy_d             = busy_q;
        done_d             = 1'b0;
        pass_d             = pass_q;
        fail_count_d       = fail_count_q;
        first_fail_vec_d   = first_fail_vec_q;
        first_fail_valid_d = first_fail_valid_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d            = APPLY;
                    vector_d           = '0;
                    busy_d             = 1'b1;
                    pass_d             = 1'b0;
                    fail_count_d       = '0;
                    first_fail_valid_d = 1'b0;
                end
            end
            APPLY: begin
                if (timer_hit) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                if (mismatch) begin
                    fail_count_d = fail_count_q + 1'b1;
                    if (!first_fail_valid_q) begin
                        first_fail_vec_d   = vector_q;
                        first_fail_valid_d = 1'b1;
                    end
                end
                // Verdict is registered on entry to FINISH so it is valid with done.
                if (vector_q == LAST_VEC) begin
                    state_d = FINISH;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (fail_count_d == '0);
                end else begin
                    state_d  = APPLY;
                    vector_d = vector_q + 1'b1;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q            <= IDLE;
            vector_q           <= '0;
            busy_q             <= 1'b0;
            done_q             <= 1'b0;
            pass_q             <= 1'b0;
            fail_count_q       <= '0;
            first_fail_vec_q   <= '0;
            first_fail_valid_q <= 1'b0;
        end else begin
            state_q            <= state_d;
            vector_q           <= vector_d;
            busy_q             <= busy_d;
            done_q             <= done_d;
            pass_q             <= pass_d;
            fail_count_q       <= fail_count_d;
            first_fail_vec_q   <= first_fail_vec_d;
            first_fail_valid_q <= first_fail_valid_d;
        end
    end

    assign dut_in           = vector_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign fail_count       = fail_count_q;
    assign first_fail_vec   = first_fail_vec_q;
    assign first_fail_valid = first_fail_valid_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Scoreboard bench: two checkers (settle 1 and 3) driving a modelled a'+bc' block.
module tb_truth_table_checker;

    typedef struct {
        int done_cyc;
        int pass;
        int fcnt;
        int ffv;
        int ffvec;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_errors = 0;

    logic       start1 = 1'b0, start2 = 1'b0;
    logic [2:0] dut_in1, dut_in2;
    logic       dut_out1, dut_out2;
    logic       busy1, busy2, done1, done2, pass1, pass2, ffv1, ffv2;
    logic [3:0] fcnt1, fcnt2;
    logic [2:0] ffvec1, ffvec2;
    int         mode1 = 0, mode2 = 0;   // 0 correct, 1 stuck-at-0, 2 stuck-at-1

    exp_t sb1[$];
    exp_t sb2[$];
    exp_t e1, e2;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign dut_out1 = (mode1 == 1) ? 1'b0 : (mode1 == 2) ? 1'b1 :
                      (~dut_in1[2] | (dut_in1[1] & ~dut_in1[0]));
    assign dut_out2 = (mode2 == 1) ? 1'b0 : (mode2 == 2) ? 1'b1 :
                      (~dut_in2[2] | (dut_in2[1] & ~dut_in2[0]));

    truth_table_checker u_dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1), .dut_in(dut_in1), .dut_out(dut_out1),
        .busy(busy1), .done(done1), .pass(pass1), .fail_count(fcnt1),
        .first_fail_vec(ffvec1), .first_fail_valid(ffv1)
    );

    truth_table_checker #(.SETTLE(3)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .start(start2), .dut_in(dut_in2), .dut_out(dut_out2),
        .busy(busy2), .done(done2), .pass(pass2), .fail_count(fcnt2),
        .first_fail_vec(ffvec2), .first_fail_valid(ffv2)
    );

    task automatic chk(input string name, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Monitors: pop an expectation whenever a checker reports completion.
    always @(negedge clk) begin
        if (reset_n && done1) begin
            if (sb1.size() == 0) begin
                chk("unexpected_done1", done1, 0);
            end else begin
                e1 = sb1.pop_front();
                chk("done_cycle1", cyc, e1.done_cyc);
                chk("pass1", pass1, e1.pass);
                chk("fail_count1", fcnt1, e1.fcnt);
                chk("first_fail_valid1", ffv1, e1.ffv);
                if (e1.ffv != 0) chk("first_fail_vec1", ffvec1, e1.ffvec);
                chk("busy_at_done1", busy1, 0);
                chk("dut_in_at_done1", dut_in1, 7);
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n && done2) begin
            if (sb2.size() == 0) begin
                chk("unexpected_done2", done2, 0);
            end else begin
                e2 = sb2.pop_front();
                chk("done_cycle2", cyc, e2.done_cyc);
                chk("pass2", pass2, e2.pass);
                chk("fail_count2", fcnt2, e2.fcnt);
                chk("first_fail_valid2", ffv2, e2.ffv);
                if (e2.ffv != 0) chk("first_fail_vec2", ffvec2, e2.ffvec);
                chk("busy_at_done2", busy2, 0);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_dut_in1"}, dut_in1, 0);  chk({tag, "_busy1"}, busy1, 0);
        chk({tag, "_done1"}, done1, 0);      chk({tag, "_pass1"}, pass1, 0);
        chk({tag, "_fcnt1"}, fcnt1, 0);      chk({tag, "_ffvec1"}, ffvec1, 0);
        chk({tag, "_ffv1"}, ffv1, 0);
        chk({tag, "_dut_in2"}, dut_in2, 0);  chk({tag, "_busy2"}, busy2, 0);
        chk({tag, "_done2"}, done2, 0);      chk({tag, "_pass2"}, pass2, 0);
        chk({tag, "_fcnt2"}, fcnt2, 0);      chk({tag, "_ffvec2"}, ffvec2, 0);
        chk({tag, "_ffv2"}, ffv2, 0);
    endtask

    task automatic wait_drain1();
        for (int i = 0; i < 200; i++) begin
            if (sb1.size() == 0 && !busy1 && !done1) break;
            @(posedge clk); #1;
        end
        chk("drain1_pending", sb1.size(), 0);
    endtask

    task automatic wait_drain2();
        for (int i = 0; i < 200; i++) begin
            if (sb2.size() == 0 && !busy2 && !done2) break;
            @(posedge clk); #1;
        end
        chk("drain2_pending", sb2.size(), 0);
    endtask

    // Pulse start on checker 1; returns the cycle number of the accepting edge.
    task automatic pulse_start1(output int acc);
        @(negedge clk); start1 = 1'b1;
        @(posedge clk); #1; start1 = 1'b0;
        acc = cyc;
    endtask

    task automatic run1(input int mode, input int fc, input int ffv, input int ffvec,
                        input int ps, input bit seq);
        int acc;
        mode1 = mode;
        pulse_start1(acc);
        sb1.push_back('{done_cyc: acc + 16, pass: ps, fcnt: fc, ffv: ffv, ffvec: ffvec});
        chk("busy_after_start1", busy1, 1);
        if (seq) begin
            for (int k = 1; k <= 16; k++) begin
                if (k > 1) begin @(posedge clk); #1; end
                chk("dut_in_step1", dut_in1, (k - 1) / 2);
                chk("busy_during1", busy1, 1);
            end
        end
        wait_drain1();
    endtask

    initial begin
        int acc;
        bit found;
        #2;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        run1(0, 0, 0, 0, 1, 1'b1);
        chk("dut_in_idle_hold1", dut_in1, 7);
        run1(1, 5, 1, 0, 0, 1'b0);
        run1(2, 3, 1, 4, 0, 1'b0);
        chk("results_hold_fcnt1", fcnt1, 3);
        chk("results_hold_ffvec1", ffvec1, 4);

        // Settle of 3: each vector held four cycles.
        mode2 = 0;
        @(negedge clk); start2 = 1'b1;
        @(posedge clk); #1; start2 = 1'b0;
        acc = cyc;
        sb2.push_back('{done_cyc: acc + 32, pass: 1, fcnt: 0, ffv: 0, ffvec: 0});
        for (int k = 1; k <= 32; k++) begin
            if (k > 1) begin @(posedge clk); #1; end
            chk("dut_in_step2", dut_in2, (k - 1) / 4);
        end
        wait_drain2();

        // Abort during vector 5 with a failing DUT, then a clean run.
        mode1 = 2;
        pulse_start1(acc);
        sb1.push_back('{done_cyc: acc + 16, pass: 0, fcnt: 3, ffv: 1, ffvec: 4});
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (dut_in1 == 3'd5) begin found = 1'b1; break; end
        end
        chk("reached_vec5", found, 1);
        chk("fcnt_before_abort", fcnt1, 1);
        #2; reset_n = 1'b0;
        #1;
        sb1.delete();
        check_reset_outputs("abort");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("busy_after_abort", busy1, 0);
        run1(0, 0, 0, 0, 1, 1'b0);

        // Start held for 40 edges: runs accepted at +0, +18 and +36.
        mode1 = 0;
        @(negedge clk); start1 = 1'b1;
        @(posedge clk); #1;
        acc = cyc;
        sb1.push_back('{done_cyc: acc + 16, pass: 1, fcnt: 0, ffv: 0, ffvec: 0});
        sb1.push_back('{done_cyc: acc + 34, pass: 1, fcnt: 0, ffv: 0, ffvec: 0});
        sb1.push_back('{done_cyc: acc + 52, pass: 1, fcnt: 0, ffv: 0, ffvec: 0});
        repeat (39) @(posedge clk);
        #1; start1 = 1'b0;
        wait_drain1();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
